// File: rtl/rps_pkg.sv
// Shared codes for the stone-paper-scissors datapath: round results, match winners,
// display selects and the match-scorer state encoding.
package rps_pkg;

    localparam logic [1:0] RES_TIE     = 2'b00;
    localparam logic [1:0] RES_P1      = 2'b01;
    localparam logic [1:0] RES_P2      = 2'b10;
    localparam logic [1:0] RES_INVALID = 2'b11;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic [1:0] SEL_P1      = 2'b00;
    localparam logic [1:0] SEL_P2      = 2'b01;
    localparam logic [1:0] SEL_TIE     = 2'b10;
    localparam logic [1:0] SEL_INVALID = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DONE
    } match_state_t;

endpackage

// File: rtl/rps_seg7_decoder.sv
// Hex digit to active-high 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module rps_seg7_decoder (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b0000000;
        case (hex)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            4'hF: seg = 7'b1110001;
            default: seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/rps_match_scorer.sv
// First-to-N match scorer: counts judged rounds, decides the match winner or a draw,
// and drives one 7-segment digit with a selectable score.
module rps_match_scorer
    import rps_pkg::*;
#(
    parameter int WINS_TO_MATCH = 3,
    parameter int MAX_ROUNDS    = 9,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             round_valid,
    input  logic [1:0]       round_result,
    input  logic             new_match,
    input  logic [1:0]       disp_sel,
    output logic [CNT_W-1:0] p1_score,
    output logic [CNT_W-1:0] p2_score,
    output logic [CNT_W-1:0] tie_cnt,
    output logic [CNT_W-1:0] invalid_cnt,
    output logic             match_over,
    output logic [1:0]       match_winner,
    output logic             round_ack,
    output logic [6:0]       seg
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] WINS_C  = CNT_W'(WINS_TO_MATCH);
    localparam logic [CNT_W+1:0] ROUNDS_C = (CNT_W+2)'(MAX_ROUNDS);

    match_state_t     state, state_next;
    logic [CNT_W-1:0] p1_next, p2_next, tie_next, invalid_next;
    logic [CNT_W+1:0] counted_next;
    logic [1:0]       winner_next;
    logic             ack_next;
    logic             accept;
    logic [CNT_W-1:0] disp_value;
    logic [3:0]       digit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            p1_score     <= '0;
            p2_score     <= '0;
            tie_cnt      <= '0;
            invalid_cnt  <= '0;
            match_winner <= WIN_NONE;
            round_ack    <= 1'b0;
        end else begin
            state        <= state_next;
            p1_score     <= p1_next;
            p2_score     <= p2_next;
            tie_cnt      <= tie_next;
            invalid_cnt  <= invalid_next;
            match_winner <= winner_next;
            round_ack    <= ack_next;
        end
    end

    // new_match always overrides a same-cycle round; rounds are frozen out once DONE.
    always_comb begin
        state_next   = state;
        p1_next      = p1_score;
        p2_next      = p2_score;
        tie_next     = tie_cnt;
        invalid_next = invalid_cnt;
        winner_next  = match_winner;
        ack_next     = 1'b0;
        accept       = round_valid && !new_match && (state != ST_DONE);

        if (new_match) begin
            p1_next      = '0;
            p2_next      = '0;
            tie_next     = '0;
            invalid_next = '0;
            winner_next  = WIN_NONE;
            state_next   = (round_valid || state == ST_DONE) ? ST_IDLE : ST_PLAY;
        end else if (accept) begin
            ack_next = 1'b1;
            case (round_result)
                RES_TIE:     tie_next     = sat_inc(tie_cnt);
                RES_P1:      p1_next      = sat_inc(p1_score);
                RES_P2:      p2_next      = sat_inc(p2_score);
                default:     invalid_next = sat_inc(invalid_cnt);
            endcase
            state_next = ST_PLAY;
        end

        counted_next = {2'b00, p1_next} + {2'b00, p2_next} + {2'b00, tie_next};

        // A player reaching the win target takes priority over the round limit draw.
        if (accept && round_result != RES_INVALID) begin
            if (p1_next == WINS_C) begin
                state_next  = ST_DONE;
                winner_next = WIN_P1;
            end else if (p2_next == WINS_C) begin
                state_next  = ST_DONE;
                winner_next = WIN_P2;
            end else if (counted_next == ROUNDS_C) begin
                state_next  = ST_DONE;
                winner_next = WIN_NONE;
            end
        end
    end

    always_comb begin
        disp_value = p1_score;
        case (disp_sel)
            SEL_P1:  disp_value = p1_score;
            SEL_P2:  disp_value = p2_score;
            SEL_TIE: disp_value = tie_cnt;
            default: disp_value = invalid_cnt;
        endcase
        digit = 4'(disp_value);
    end

    assign match_over = (state == ST_DONE);

    rps_seg7_decoder u_seg7 (
        .hex (digit),
        .seg (seg)
    );

endmodule

// File: tb/tb_rps_match_scorer.sv
// Randomized scoreboard bench for rps_match_scorer, plus a narrow-counter saturation instance.
module tb_rps_match_scorer;
    import rps_pkg::*;

    localparam int W    = 3;
    localparam int M    = 9;
    localparam int SMAX = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       round_valid = 1'b0;
    logic [1:0] round_result = 2'b00;
    logic       new_match = 1'b0;
    logic [1:0] disp_sel = 2'b00;
    logic [3:0] p1_score, p2_score, tie_cnt, invalid_cnt;
    logic       match_over, round_ack;
    logic [1:0] match_winner;
    logic [6:0] seg;

    logic       s_rst = 1'b1;
    logic       s_rv = 1'b0;
    logic [1:0] s_res = 2'b00;
    logic       s_nm = 1'b0;
    logic [1:0] s_sel = 2'b11;
    logic [1:0] s_p1, s_p2, s_tie, s_inv;
    logic       s_over, s_ack;
    logic [1:0] s_winner;
    logic [6:0] s_seg;

    always #5 clk = ~clk;

    rps_match_scorer #(.WINS_TO_MATCH(W), .MAX_ROUNDS(M), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .round_valid(round_valid), .round_result(round_result),
        .new_match(new_match), .disp_sel(disp_sel), .p1_score(p1_score), .p2_score(p2_score),
        .tie_cnt(tie_cnt), .invalid_cnt(invalid_cnt), .match_over(match_over),
        .match_winner(match_winner), .round_ack(round_ack), .seg(seg)
    );

    rps_match_scorer #(.WINS_TO_MATCH(3), .MAX_ROUNDS(9), .CNT_W(2)) dut_small (
        .clk(clk), .rst(s_rst), .round_valid(s_rv), .round_result(s_res),
        .new_match(s_nm), .disp_sel(s_sel), .p1_score(s_p1), .p2_score(s_p2),
        .tie_cnt(s_tie), .invalid_cnt(s_inv), .match_over(s_over),
        .match_winner(s_winner), .round_ack(s_ack), .seg(s_seg)
    );

    typedef struct {
        int p1;
        int p2;
        int tie;
        int inv;
        bit over;
        int winner;
        bit chk_winner;
        bit ack;
        int seg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int m_p1 = 0, m_p2 = 0, m_tie = 0, m_inv = 0, m_winner = 0;
    bit m_over = 1'b0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
        end
    endtask

    // One call drives one clock cycle and queues the state the DUT must show after that edge.
    task automatic applyStimulus(input bit r, input bit rv, input logic [1:0] res,
                                 input bit nm, input logic [1:0] sel);
        exp_t e;
        int   shown;
        @(negedge clk);
        rst          = r;
        round_valid  = rv;
        round_result = res;
        new_match    = nm;
        disp_sel     = sel;
        e.ack = 1'b0;
        if (r || nm) begin
            m_p1 = 0; m_p2 = 0; m_tie = 0; m_inv = 0;
            m_over = 1'b0; m_winner = 0;
        end else if (rv && !m_over) begin
            e.ack = 1'b1;
            case (res)
                2'd0: m_tie = (m_tie < SMAX) ? m_tie + 1 : m_tie;
                2'd1: m_p1  = (m_p1  < SMAX) ? m_p1  + 1 : m_p1;
                2'd2: m_p2  = (m_p2  < SMAX) ? m_p2  + 1 : m_p2;
                default: m_inv = (m_inv < SMAX) ? m_inv + 1 : m_inv;
            endcase
            if (res != 2'd3) begin
                if (m_p1 == W)                      begin m_over = 1'b1; m_winner = 1; end
                else if (m_p2 == W)                 begin m_over = 1'b1; m_winner = 2; end
                else if (m_p1 + m_p2 + m_tie == M)  begin m_over = 1'b1; m_winner = 0; end
            end
        end
        e.p1 = m_p1; e.p2 = m_p2; e.tie = m_tie; e.inv = m_inv;
        e.over = m_over; e.winner = m_winner;
        e.chk_winner = m_over || r;
        shown = (sel == 2'd0) ? m_p1 : (sel == 2'd1) ? m_p2 : (sel == 2'd2) ? m_tie : m_inv;
        e.seg = int'(seg_tab[shown & 15]);
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("p1_score", p1_score, e.p1);
                checkOutput("p2_score", p2_score, e.p2);
                checkOutput("tie_cnt", tie_cnt, e.tie);
                checkOutput("invalid_cnt", invalid_cnt, e.inv);
                checkOutput("match_over", match_over, e.over);
                checkOutput("round_ack", round_ack, e.ack);
                checkOutput("seg", seg, e.seg);
                if (e.chk_winner)
                    checkOutput("match_winner", match_winner, e.winner);
            end
        end
    end

    task automatic playRounds(input int n, input logic [1:0] seq [16], input logic [1:0] sel);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b1, seq[i], 1'b0, sel);
    endtask

    initial begin : stimulus
        logic [1:0] seq [16];
        $display("[TB] start");
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 2'd0);

        seq = '{2'd1, 2'd1, 2'd1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        playRounds(4, seq, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd1);
        checkOutput("win3_p1", p1_score, 3);
        checkOutput("win3_p2_frozen", p2_score, 0);
        checkOutput("win3_winner", match_winner, 1);

        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd0);
        seq = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        playRounds(5, seq, 2'd3);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd3);
        checkOutput("mixed_seg_invalid", seg, 7'b0000110);
        checkOutput("mixed_tie", tie_cnt, 2);

        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd2);
        seq = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd1, 0, 0, 0};
        playRounds(13, seq, 2'd2);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd2);
        checkOutput("draw_over", match_over, 1);
        checkOutput("draw_winner", match_winner, 0);

        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd0);
        seq = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0, 0, 0, 0};
        playRounds(9, seq, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd0);

        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd0);
        seq = '{2'd1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        playRounds(2, seq, 2'd1);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd1);
        playRounds(2, seq, 2'd0);
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd0);

        for (int i = 0; i < 40; i++)
            applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 2'd3);

        for (int i = 0; i < 2000; i++)
            applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                          2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0,
                          2'($urandom_range(0, 3)));
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd0);

        @(negedge clk);
        s_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_rv = 1'b1;
            s_res = 2'd3;
        end
        @(negedge clk);
        s_rv = 1'b0;
        checkOutput("sat_invalid", s_inv, 3);
        checkOutput("sat_over", s_over, 0);
        checkOutput("sat_seg", s_seg, 7'h4F);
        s_rv = 1'b1;
        s_res = 2'd1;
        @(negedge clk);
        s_rv = 1'b0;
        checkOutput("sat_p1", s_p1, 1);
        checkOutput("sat_ack", s_ack, 1);

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
